// File: rtl/pinv_row_reader.sv
// Streams a contiguous range of rows from the flat pseudoinverse ROM bus as ELEM_W-bit elements, MSB element first.
// Build option PINV_PREFETCH_EN: a second row register loads the next row during streaming, which removes the inter-row LOAD bubble.
module pinv_row_reader #(
    parameter int N      = 38016,
    parameter int ROW_W  = 384,
    parameter int ELEM_W = 16,
    parameter int ROWS   = N / ROW_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      pinv_in,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [6:0]        req_row,
    input  logic [6:0]        req_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err
);
    // state    | meaning
    // S_IDLE   | waiting for a request, req_ready high
    // S_LOAD   | copying the current row slice into the row register
    // S_STREAM | presenting one element per accepted beat
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    localparam int EPR = ROW_W / ELEM_W;
    localparam int IW  = $clog2(EPR);
    localparam logic [IW-1:0] IDX_LAST = IW'(EPR - 1);

    logic [1:0]        state;
    logic [6:0]        row_cnt;
    logic [6:0]        rem_cnt;
    logic [IW-1:0]     idx;
    logic [ROW_W-1:0]  row_reg;
    logic              err_q;
    logic [ELEM_W-1:0] elem;
    logic              accept;
    logic              bad_req;
    logic              beat;
`ifdef PINV_PREFETCH_EN
    logic [ROW_W-1:0]  nxt_reg;
`endif

    function automatic logic [ROW_W-1:0] row_slice(input logic [N-1:0] bus, input logic [6:0] r);
        logic [ROW_W-1:0] s;
        s = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (r == 7'(i)) s = bus[i*ROW_W +: ROW_W];
        end
        return s;
    endfunction

    always_comb begin
        elem = '0;
        for (int k = 0; k < EPR; k++) begin
            if (idx == IW'(k)) elem = row_reg[ROW_W-1-k*ELEM_W -: ELEM_W];
        end
    end

    // Range check is done at 8 bits so req_row+req_len cannot wrap.
    assign bad_req = (req_len == 7'd0) || (({1'b0, req_row} + {1'b0, req_len}) > 8'(ROWS));
    assign accept  = req_valid && req_ready;
    assign beat    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            row_cnt <= '0;
            rem_cnt <= '0;
            idx     <= '0;
            row_reg <= '0;
            err_q   <= 1'b0;
`ifdef PINV_PREFETCH_EN
            nxt_reg <= '0;
`endif
        end else begin
            err_q <= accept && bad_req;
            case (state)
                S_IDLE: begin
                    if (accept && !bad_req) begin
                        row_cnt <= req_row;
                        rem_cnt <= req_len;
                        idx     <= '0;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    row_reg <= row_slice(pinv_in, row_cnt);
                    state   <= S_STREAM;
                end
                S_STREAM: begin
                    if (beat) begin
                        if (idx != IDX_LAST) begin
                            idx <= idx + IW'(1);
                        end else if (rem_cnt != 7'd1) begin
                            rem_cnt <= rem_cnt - 7'd1;
                            row_cnt <= row_cnt + 7'd1;
                            idx     <= '0;
`ifdef PINV_PREFETCH_EN
                            row_reg <= nxt_reg;
`else
                            state   <= S_LOAD;
`endif
                        end else begin
                            idx   <= '0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
`ifdef PINV_PREFETCH_EN
            // Only prefetch while another row remains, so nothing past the final row is fetched.
            if (state == S_STREAM && rem_cnt > 7'd1)
                nxt_reg <= row_slice(pinv_in, row_cnt + 7'd1);
`endif
        end
    end

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_STREAM);
    assign out_data  = out_valid ? elem : '0;
    assign out_last  = out_valid && (rem_cnt == 7'd1) && (idx == IDX_LAST);
    assign err       = err_q;

endmodule

// File: tb/tb_pinv_row_reader.sv
// Self-checking bench for pinv_row_reader: a ROM image with known anchor words, an element-queue model,
// a request table, hand-written reset/stall/poke sequences and randomized requests.
module tb_pinv_row_reader;
    localparam int N      = 38016;
    localparam int ROW_W  = 384;
    localparam int ELEM_W = 16;
    localparam int ROWS   = 99;
    localparam int EPR    = 24;
`ifdef PINV_PREFETCH_EN
    localparam int PF = 1;
`else
    localparam int PF = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      pinv;
    logic              req_valid;
    logic              req_ready;
    logic [6:0]        req_row;
    logic [6:0]        req_len;
    logic              out_valid;
    logic              out_ready;
    logic [ELEM_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    pinv_row_reader dut (
        .clk       (clk),
        .rst       (rst),
        .pinv_in   (pinv),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_row   (req_row),
        .req_len   (req_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    int total = 0;
    int bad   = 0;
    logic [15:0] rom [ROWS][EPR];
    logic [15:0] got_q [$];

    typedef struct {
        int row;
        int len;
        int rmode;
        bit poke;
        bit exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one sample point after a posedge with the DUT idle. rmode 0: out_ready always 1, 1: random.
    task automatic run_req(input int row, input int len, input int rmode, input bit poke, input bit exp_err);
        logic [15:0] exp_q [$];
        logic [15:0] prev_data;
        bit          prev_stall;
        int          cyc, first, bubbles, limit;
        got_q.delete();
        chk("idle_ready", 32'(req_ready), 1);
        req_row   = 7'(row);
        req_len   = 7'(len);
        req_valid = 1'b1;
        out_ready = 1'b1;
        step();
        req_valid = 1'b0;
        if (exp_err) begin
            chk("err_pulse", 32'(err), 1);
            chk("err_busy", 32'(busy), 0);
            chk("err_valid", 32'(out_valid), 0);
            step();
            chk("err_once", 32'(err), 0);
            chk("err_idle", 32'(req_ready), 1);
            chk("err_valid2", 32'(out_valid), 0);
            return;
        end
        chk("acc_noerr", 32'(err), 0);
        chk("load_busy", 32'(busy), 1);
        chk("load_valid", 32'(out_valid), 0);
        for (int r = row; r < row + len; r++)
            for (int k = 0; k < EPR; k++)
                exp_q.push_back(rom[r][k]);
        cyc = 1; first = -1; bubbles = 0; prev_stall = 0; prev_data = '0;
        limit = 60 * len + 40;
        while (exp_q.size() > 0 && cyc < limit) begin
            out_ready = (rmode == 0) ? 1'b1 : 1'($urandom % 2);
            req_valid = poke && (cyc == 10);
            if (poke && cyc == 11) chk("poke_noerr", 32'(err), 0);
            chk("stream_busy", 32'(busy), 1);
            if (out_valid) begin
                if (first < 0) first = cyc;
                if (prev_stall) chk("stall_hold", 32'(out_data), 32'(prev_data));
                chk("beat_last", 32'(out_last), 32'(exp_q.size() == 1));
                if (out_ready) begin
                    chk("beat_data", 32'(out_data), 32'(exp_q[0]));
                    got_q.push_back(out_data);
                    void'(exp_q.pop_front());
                end
                prev_stall = !out_ready;
                prev_data  = out_data;
            end else begin
                if (first >= 0) bubbles++;
                prev_stall = 0;
            end
            step();
            cyc++;
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        chk("beats_left", 32'(exp_q.size()), 0);
        chk("first_lat", 32'(first), 2);
        chk("bubbles", 32'(bubbles), 32'(PF != 0 ? 0 : len - 1));
        chk("b2b_ready", 32'(req_ready), 1);
        chk("idle_valid", 32'(out_valid), 0);
        if (rmode == 0) chk("duration", 32'(cyc), 32'(PF != 0 ? 2 + 24 * len : 2 + 24 * len + len - 1));
    endtask

    initial begin
        vec_t tbl [8];
        int n, c;
        tbl = '{
            '{5, 4, 0, 0, 0},
            '{10, 3, 1, 0, 0},
            '{5, 0, 0, 0, 1},
            '{30, 2, 0, 1, 0},
            '{0, 99, 0, 0, 0},
            '{1, 98, 1, 0, 0},
            '{99, 1, 0, 0, 1},
            '{127, 127, 0, 0, 1}
        };

        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < EPR; k++)
                rom[r][k] = 16'($urandom);
        rom[0][0]   = 16'h0f00;
        rom[0][1]   = 16'h0f00;
        rom[0][2]   = 16'h0ff0;
        rom[0][23]  = 16'h5cdf;
        rom[98][0]  = 16'h0ff0;
        rom[98][23] = 16'he414;
        pinv = '0;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < EPR; k++)
                pinv[r*ROW_W + ROW_W-1-k*ELEM_W -: ELEM_W] = rom[r][k];

        rst = 1'b1; req_valid = 1'b0; req_row = '0; req_len = '0; out_ready = 1'b0;
        step(); step(); step();
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        step();

        run_req(0, 1, 0, 0, 0);
        chk("r0_count", 32'(got_q.size()), 24);
        if (got_q.size() >= 24) begin
            chk("r0_beat1", 32'(got_q[0]), 32'h0f00);
            chk("r0_beat2", 32'(got_q[1]), 32'h0f00);
            chk("r0_beat3", 32'(got_q[2]), 32'h0ff0);
            chk("r0_beat24", 32'(got_q[23]), 32'h5cdf);
        end

        run_req(97, 2, 0, 0, 0);
        chk("r97_count", 32'(got_q.size()), 48);
        if (got_q.size() >= 48) begin
            chk("r97_beat25", 32'(got_q[24]), 32'h0ff0);
            chk("r97_beat48", 32'(got_q[47]), 32'he414);
        end

        run_req(10, 3, 1, 0, 0);
        chk("r10_count", 32'(got_q.size()), 72);

        run_req(0, 0, 0, 0, 1);
        run_req(98, 2, 0, 0, 1);

        // Reset in the middle of a 4-row transfer.
        req_row = 7'd5; req_len = 7'd4; req_valid = 1'b1; out_ready = 1'b1;
        step();
        req_valid = 1'b0;
        n = 0; c = 0;
        while (n < 5 && c < 20) begin
            if (out_valid) n++;
            step();
            c++;
        end
        chk("mid_beats", 32'(n), 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ready", 32'(req_ready), 1);
        chk("mid_rst_last", 32'(out_last), 0);
        step();
        chk("mid_rst_idle", 32'(busy), 0);
        run_req(0, 1, 0, 0, 0);
        chk("post_rst_count", 32'(got_q.size()), 24);
        if (got_q.size() >= 1) chk("post_rst_first", 32'(got_q[0]), 32'h0f00);

        run_req(20, 2, 1, 1, 0);

        for (int i = 0; i < 8; i++)
            run_req(tbl[i].row, tbl[i].len, tbl[i].rmode, tbl[i].poke, tbl[i].exp_err);

        for (int i = 0; i < 10; i++) begin
            int r, l, m;
            bit e;
            r = $urandom_range(98, 0);
            if ($urandom % 4 == 0) begin
                l = (i % 2 != 0) ? 0 : $urandom_range(127, 100 - r);
                e = 1'b1;
            end else begin
                m = (99 - r < 6) ? 99 - r : 6;
                l = $urandom_range(m, 1);
                e = 1'b0;
            end
            run_req(r, l, $urandom % 2, 1'($urandom % 2), e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
